// File: rtl/hit_edge_detector.sv
// hit_edge_detector: per-frame smiley collision detector with edge classification
module hit_edge_detector #(
    parameter int OBJ_W           = 32,
    parameter int OBJ_H           = 32,
    parameter int EDGE_W          = 4,
    parameter int COOLDOWN_FRAMES = 2
) (
    input  logic               clk,
    input  logic               resetN,
    input  logic               startOfFrame,
    input  logic [10:0]        pixelX,
    input  logic [10:0]        pixelY,
    input  logic signed [10:0] topLeftX,
    input  logic signed [10:0] topLeftY,
    input  logic               smileyDR,
    input  logic               brickDR,
    input  logic               borderDR,
    output logic               collision,
    output logic [3:0]         HitEdgeCode
);
    typedef enum logic {S_COLLECT, S_REPORT} state_t;
    localparam int CW = $clog2(COOLDOWN_FRAMES + 2);
    localparam logic [CW-1:0] COOL_LOAD = CW'(COOLDOWN_FRAMES);
    localparam logic [10:0] W_L = 11'(OBJ_W);
    localparam logic [10:0] H_L = 11'(OBJ_H);
    localparam logic [10:0] E_L = 11'(EDGE_W);
    localparam logic [10:0] R_L = 11'(OBJ_W - EDGE_W);
    localparam logic [10:0] B_L = 11'(OBJ_H - EDGE_W);
    logic signed [11:0] off_x, off_y;
    logic               hit, in_x, in_y;
    logic [3:0]         stg_d, stg_q, accum_d, accum_q, code_d, code_q, snap;
    logic [CW-1:0]      cool_d, cool_q;
    state_t             state_d, state_q;
    // stage 1: classify the current pixel against the smiley's edge bands
    always_comb begin
        hit   = smileyDR & (brickDR | borderDR);
        off_x = {1'b0, pixelX} - {topLeftX[10], topLeftX};
        off_y = {1'b0, pixelY} - {topLeftY[10], topLeftY};
        in_x  = !off_x[11] && (off_x[10:0] < W_L);
        in_y  = !off_y[11] && (off_y[10:0] < H_L);
        stg_d = (hit && in_x && in_y) ? {off_x[10:0] < E_L, off_y[10:0] < E_L,
                                         off_x[10:0] >= R_L, off_y[10:0] >= B_L} : 4'b0;
    end
    // frame accumulation, report FSM and cooldown bookkeeping
    always_comb begin
        snap    = accum_q | stg_q;
        accum_d = startOfFrame ? 4'b0 : snap;
        state_d = state_q;
        cool_d  = cool_q;
        code_d  = code_q;
        if (state_q == S_REPORT) begin
            state_d = S_COLLECT;
            cool_d  = COOL_LOAD;
        end else if (startOfFrame) begin
            if (cool_q != '0) begin
                cool_d = cool_q - 1'b1;
            end else if (snap != 4'b0) begin
                code_d  = snap;
                state_d = S_REPORT;
            end
        end
    end
    assign collision   = (state_q == S_REPORT);
    assign HitEdgeCode = code_q;
    // state registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!resetN) begin
            stg_q   <= 4'b0;
            accum_q <= 4'b0;
            code_q  <= 4'b0;
            cool_q  <= '0;
            state_q <= S_COLLECT;
        end else begin
            stg_q   <= stg_d;
            accum_q <= accum_d;
            code_q  <= code_d;
            cool_q  <= cool_d;
            state_q <= state_d;
        end
    end
endmodule
